// File: rtl/time_entry.sv
`default_nettype none
// ============================================================================
// Module   : time_entry
// Brief    : Keypad HH:MM entry. Position-checked BCD digits with ENTER/CLEAR
//            and an inactivity timeout; commits binary hours/minutes.
// Revision : 1.0 - initial release
// ============================================================================
module time_entry #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        set_time,
    output logic [5:0]  new_time_hr,
    output logic [5:0]  new_time_min,
    output logic [15:0] entry_display,
    output logic        entry_active,
    output logic        entry_error
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_entry  = 2'd1;
    localparam logic [1:0] c_ready  = 2'd2;
    localparam logic [1:0] c_commit = 2'd3;

    // Timer holds 0..TIMEOUT_CYCLES-1; abandon on the edge it would reach TIMEOUT_CYCLES.
    localparam int              c_tw    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tw-1:0] c_tlast = c_tw'(TIMEOUT_CYCLES - 1);

    logic [1:0]      r_state;
    logic [2:0]      r_count;
    logic [15:0]     r_digits;
    logic [c_tw-1:0] r_timer;
    logic            r_error;
    logic [5:0]      r_hr;
    logic [5:0]      r_min;

    logic            w_digit;
    logic            w_enter;
    logic            w_clear;
    logic            w_digit_ok;
    logic            w_timeout;
    logic [5:0]      w_hr;
    logic [5:0]      w_min;

    assign w_digit   = key_valid && (key_code <= 4'd9);
    assign w_enter   = key_valid && (key_code == 4'hA);
    assign w_clear   = key_valid && (key_code == 4'hB);
    assign w_timeout = (r_timer == c_tlast);

    assign w_hr  = 6'(r_digits[15:12]) * 6'd10 + 6'(r_digits[11:8]);
    assign w_min = 6'(r_digits[7:4])   * 6'd10 + 6'(r_digits[3:0]);

    always_comb begin
        w_digit_ok = 1'b1;
        case (r_count)
            3'd0:    w_digit_ok = (key_code <= 4'd2);
            3'd1:    w_digit_ok = (r_digits[15:12] == 4'd2) ? (key_code <= 4'd3) : 1'b1;
            3'd2:    w_digit_ok = (key_code <= 4'd5);
            default: w_digit_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_count  <= 3'd0;
            r_digits <= 16'h0000;
            r_timer  <= '0;
            r_error  <= 1'b0;
            r_hr     <= 6'd0;
            r_min    <= 6'd0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_timer <= '0;
                    if (w_clear) begin
                        r_digits <= 16'h0000;
                        r_count  <= 3'd0;
                    end else if (w_enter) begin
                        r_error <= 1'b1;
                    end else if (w_digit) begin
                        if (w_digit_ok) begin
                            r_digits[15:12] <= key_code;
                            r_count         <= 3'd1;
                            r_state         <= c_entry;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                c_entry: begin
                    if (w_clear) begin
                        r_state  <= c_idle;
                        r_digits <= 16'h0000;
                        r_count  <= 3'd0;
                        r_timer  <= '0;
                    end else if (w_enter) begin
                        r_error <= 1'b1;
                        r_timer <= '0;
                    end else if (w_digit) begin
                        r_timer <= '0;
                        if (w_digit_ok) begin
                            case (r_count)
                                3'd1:    r_digits[11:8] <= key_code;
                                3'd2:    r_digits[7:4]  <= key_code;
                                default: r_digits[3:0]  <= key_code;
                            endcase
                            r_count <= r_count + 3'd1;
                            if (r_count == 3'd3)
                                r_state <= c_ready;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state  <= c_idle;
                        r_digits <= 16'h0000;
                        r_count  <= 3'd0;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ready: begin
                    if (w_clear) begin
                        r_state  <= c_idle;
                        r_digits <= 16'h0000;
                        r_count  <= 3'd0;
                        r_timer  <= '0;
                    end else if (w_enter) begin
                        r_state <= c_commit;
                        r_hr    <= w_hr;
                        r_min   <= w_min;
                        r_timer <= '0;
                    end else if (w_digit) begin
                        r_error <= 1'b1;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state  <= c_idle;
                        r_digits <= 16'h0000;
                        r_count  <= 3'd0;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    // Any key arriving while committing is dropped silently.
                    r_state  <= c_idle;
                    r_digits <= 16'h0000;
                    r_count  <= 3'd0;
                    r_timer  <= '0;
                end
            endcase
        end
    end

    assign set_time      = (r_state == c_commit);
    assign entry_active  = (r_state == c_entry) || (r_state == c_ready);
    assign entry_error   = r_error;
    assign entry_display = r_digits;
    assign new_time_hr   = r_hr;
    assign new_time_min  = r_min;

endmodule
`default_nettype wire

// File: tb/tb_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_entry
// Brief    : Directed vector-table bench for time_entry plus multi-cycle cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_entry;

    localparam int T = 20;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        set_time;
    logic [5:0]  new_time_hr;
    logic [5:0]  new_time_min;
    logic [15:0] entry_display;
    logic        entry_active;
    logic        entry_error;

    time_entry #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .set_time      (set_time),
        .new_time_hr   (new_time_hr),
        .new_time_min  (new_time_min),
        .entry_display (entry_display),
        .entry_active  (entry_active),
        .entry_error   (entry_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic [15:0] disp;
        logic        err;
        logic        act;
        logic        set;
        logic [5:0]  hr_e;
        logic [5:0]  min_e;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic kv, logic [3:0] code, logic [15:0] disp, logic err,
                                logic act, logic set, logic [5:0] hr_e, logic [5:0] min_e);
        vec_t v;
        v.kv = kv; v.code = code; v.disp = disp; v.err = err;
        v.act = act; v.set = set; v.hr_e = hr_e; v.min_e = min_e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " disp"}, entry_display, v.disp);
        chk({tag, " err"}, 16'(entry_error), 16'(v.err));
        chk({tag, " act"}, 16'(entry_active), 16'(v.act));
        chk({tag, " set"}, 16'(set_time), 16'(v.set));
        chk({tag, " hr"}, 16'(new_time_hr), 16'(v.hr_e));
        chk({tag, " min"}, 16'(new_time_min), 16'(v.min_e));
    endtask

    // Present one key (or idle cycle) for one clock, then check at the next falling edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        key_valid = v.kv;
        key_code  = v.code;
        @(negedge clk);
        key_valid = 1'b0;
        chk_outs(tag, v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        vec_t z;

        // misc IDLE behaviour
        tbl.push_back(mk(1, 4'hA, 16'h0000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 16'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 1, 0, 0, 0, 0));
        // 1,2,3,4,ENTER
        tbl.push_back(mk(1, 4'h1, 16'h1000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 16'h1200, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h1230, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 16'h1234, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 16'h1234, 0, 0, 1, 12, 34));
        tbl.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 12, 34));
        // 2,4(bad),3,5,9,ENTER
        tbl.push_back(mk(1, 4'h2, 16'h2000, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h4, 16'h2000, 1, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h3, 16'h2300, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h5, 16'h2350, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h9, 16'h2359, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'hA, 16'h2359, 0, 0, 1, 23, 59));
        tbl.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 23, 59));
        // 1,2,ENTER(early),CLEAR
        tbl.push_back(mk(1, 4'h1, 16'h1000, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'h2, 16'h1200, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'hA, 16'h1200, 1, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'hB, 16'h0000, 0, 0, 0, 23, 59));
        // 1,2,3,4,7(in READY),ENTER
        tbl.push_back(mk(1, 4'h1, 16'h1000, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'h2, 16'h1200, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'h3, 16'h1230, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'h4, 16'h1234, 0, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'h7, 16'h1234, 1, 1, 0, 23, 59));
        tbl.push_back(mk(1, 4'hA, 16'h1234, 0, 0, 1, 12, 34));
        tbl.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 12, 34));
        // min tens limit, ignored code mid-entry, CLEAR
        tbl.push_back(mk(1, 4'h1, 16'h1000, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h0, 16'h1000, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'h6, 16'h1000, 1, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'hF, 16'h1000, 0, 1, 0, 12, 34));
        tbl.push_back(mk(1, 4'hB, 16'h0000, 0, 0, 0, 12, 34));

        reset     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        chk_outs("reset", mk(0, 4'h0, 16'h0000, 0, 0, 0, 0, 0));
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // key during COMMIT is dropped without error
        step(mk(1, 4'h0, 16'h0000, 0, 1, 0, 12, 34), "cd0");
        step(mk(1, 4'h1, 16'h0100, 0, 1, 0, 12, 34), "cd1");
        step(mk(1, 4'h0, 16'h0100, 0, 1, 0, 12, 34), "cd2");
        step(mk(1, 4'h5, 16'h0105, 0, 1, 0, 12, 34), "cd3");
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'hA;
        @(negedge clk);
        key_code = 4'h5;
        chk_outs("cd commit", mk(0, 4'h0, 16'h0105, 0, 0, 1, 1, 5));
        @(negedge clk);
        key_valid = 1'b0;
        chk_outs("cd drop", mk(0, 4'h0, 16'h0000, 0, 0, 0, 1, 5));

        // timeout with an ignored code in the middle that must not restart it
        step(mk(1, 4'h0, 16'h0000, 0, 1, 0, 1, 5), "to0");
        step(mk(1, 4'h9, 16'h0900, 0, 1, 0, 1, 5), "to1");
        seen = 0;
        for (int i = 1; i <= T - 1; i++) begin
            @(negedge clk);
            key_valid = (i == 5);
            key_code  = 4'hF;
            if (set_time || entry_error) seen++;
        end
        chk_outs("to pre", mk(0, 4'h0, 16'h0900, 0, 1, 0, 1, 5));
        @(negedge clk);
        chk_outs("to hit", mk(0, 4'h0, 16'h0000, 0, 0, 0, 1, 5));
        chk("to no pulses", 16'(seen), 16'd0);

        // a key landing on the timeout cycle wins
        step(mk(1, 4'h0, 16'h0000, 0, 1, 0, 1, 5), "tk0");
        step(mk(1, 4'h9, 16'h0900, 0, 1, 0, 1, 5), "tk1");
        repeat (T - 1) @(negedge clk);
        key_valid = 1'b1; key_code = 4'h1;
        @(negedge clk);
        key_valid = 1'b0;
        chk_outs("tk key", mk(0, 4'h0, 16'h0910, 0, 1, 0, 1, 5));
        step(mk(1, 4'hB, 16'h0000, 0, 0, 0, 1, 5), "tk clr");

        // reset mid-entry, then a fresh 07:00
        step(mk(1, 4'h1, 16'h1000, 0, 1, 0, 1, 5), "rm0");
        step(mk(1, 4'h5, 16'h1500, 0, 1, 0, 1, 5), "rm1");
        step(mk(1, 4'h3, 16'h1530, 0, 1, 0, 1, 5), "rm2");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outs("rm async", mk(0, 4'h0, 16'h0000, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(mk(1, 4'h0, 16'h0000, 0, 1, 0, 0, 0), "rm3");
        step(mk(1, 4'h7, 16'h0700, 0, 1, 0, 0, 0), "rm4");
        step(mk(1, 4'h0, 16'h0700, 0, 1, 0, 0, 0), "rm5");
        step(mk(1, 4'h0, 16'h0700, 0, 1, 0, 0, 0), "rm6");
        step(mk(1, 4'hA, 16'h0700, 0, 0, 1, 7, 0), "rm7");
        step(mk(0, 4'h0, 16'h0000, 0, 0, 0, 7, 0), "rm8");

        // reset during COMMIT aborts; next key is handled from IDLE
        step(mk(1, 4'h2, 16'h2000, 0, 1, 0, 7, 0), "rc0");
        step(mk(1, 4'h1, 16'h2100, 0, 1, 0, 7, 0), "rc1");
        step(mk(1, 4'h4, 16'h2140, 0, 1, 0, 7, 0), "rc2");
        step(mk(1, 4'h5, 16'h2145, 0, 1, 0, 7, 0), "rc3");
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        chk_outs("rc commit", mk(0, 4'h0, 16'h2145, 0, 0, 1, 21, 45));
        reset = 1'b0;
        #1;
        chk_outs("rc async", mk(0, 4'h0, 16'h0000, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (set_time) seen++;
        end
        chk("rc no set", 16'(seen), 16'd0);
        step(mk(1, 4'h3, 16'h0000, 1, 0, 0, 0, 0), "rc4");
        step(mk(1, 4'h1, 16'h1000, 0, 1, 0, 0, 0), "rc5");
        z = mk(1, 4'hB, 16'h0000, 0, 0, 0, 0, 0);
        step(z, "rc clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
